arbiter_rr_hold: RTL

Parametrised N-requester bus arbiter with registered one-hot grant, tenure hold, and selectable round-robin or fixed-priority mode. It is the next-generation arbiter for the shared bus. The grant is held for a whole transfer rather than re-decided every cycle. A programmable hold timeout stops any requester from starving the others.

---
 rtl/arb_pkg.sv | 25 ++
 rtl/prio_pick_lsb.sv | 12 +
 rtl/arbiter_rr_hold.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin / fixed-priority bus arbiter.
package arb_pkg;

    localparam int unsigned ARB_MAX_N = 64;

    typedef enum logic {
        ARB_IDLE,
        ARB_BUSY
    } arb_state_e;

    function automatic int unsigned ARB_IDX_W(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Index of the set bit of a one-hot vector; 0 for an all-zero vector.
    function automatic int unsigned onehot_to_idx(input logic [ARB_MAX_N-1:0] oh);
        int unsigned idx;
        idx = 0;
        for (int unsigned i = 0; i < ARB_MAX_N; i++) begin
            if (oh[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/prio_pick_lsb.sv
// Combinational lowest-set-bit picker: returns a one-hot (or zero) vector.
module prio_pick_lsb #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] req,
    output logic [N-1:0] pick_c
);

    // Two's-complement trick isolates the lowest set bit.
    assign pick_c = req & (~req + N'(1));

endmodule

// File: rtl/arbiter_rr_hold.sv
// N-requester bus arbiter: registered one-hot grant held for a whole tenure,
// round-robin or fixed priority, with an optional hold-limit timeout.
module arbiter_rr_hold
    import arb_pkg::*;
#(
    parameter int unsigned N          = 4,
    parameter int unsigned MAX_HOLD   = 16,
    parameter int unsigned FIXED_PRIO = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N-1:0]              req,
    input  logic                      done,
    output logic [N-1:0]              grant,
    output logic                      grant_valid,
    output logic [ARB_IDX_W(N)-1:0]   grant_id,
    output logic                      timeout
);

    localparam int unsigned IDX_W  = ARB_IDX_W(N);
    localparam int unsigned HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
    localparam logic [IDX_W-1:0]  PTR_RST  = IDX_W'(N - 1);

    arb_state_e        state_q, state_d;
    logic [N-1:0]      grant_q, grant_d;
    logic              grant_valid_q, grant_valid_d;
    logic [IDX_W-1:0]  grant_id_q, grant_id_d;
    logic              timeout_q, timeout_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

    logic [IDX_W-1:0]  pick_ptr;
    logic [N-1:0]      rr_mask;
    logic [N-1:0]      pick_masked;
    logic [N-1:0]      pick_all;
    logic [N-1:0]      pick;
    logic              owner_drop;
    logic              hold_hit;
    logic              tenure_end;

    // At end of tenure the pointer is treated as already moved to the owner.
    always_comb begin
        pick_ptr = (state_q == ARB_BUSY) ? grant_id_q : ptr_q;
        rr_mask  = '0;
        for (int i = 0; i < int'(N); i++) begin
            rr_mask[i] = (i > int'(pick_ptr));
        end
    end

    prio_pick_lsb #(.N(N)) u_pick_masked (
        .req    (req & rr_mask),
        .pick_c (pick_masked)
    );

    prio_pick_lsb #(.N(N)) u_pick_all (
        .req    (req),
        .pick_c (pick_all)
    );

    always_comb begin
        if (FIXED_PRIO != 0) begin
            pick = pick_all;
        end else begin
            pick = (|pick_masked) ? pick_masked : pick_all;
        end
    end

    assign owner_drop = ~|(req & grant_q);
    assign hold_hit   = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_MAX);
    assign tenure_end = done | owner_drop | hold_hit;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        timeout_d  = 1'b0;

        unique case (state_q)
            ARB_IDLE: begin
                if (|req) begin
                    grant_d    = pick;
                    hold_cnt_d = '0;
                    state_d    = ARB_BUSY;
                end else begin
                    grant_d = '0;
                end
            end
            ARB_BUSY: begin
                if (tenure_end) begin
                    timeout_d  = hold_hit & ~done & ~owner_drop;
                    ptr_d      = grant_id_q;
                    hold_cnt_d = '0;
                    if (|req) begin
                        grant_d = pick;
                    end else begin
                        grant_d = '0;
                        state_d = ARB_IDLE;
                    end
                end else if ((MAX_HOLD != 0) && (hold_cnt_q != HOLD_MAX)) begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            default: begin
                state_d = ARB_IDLE;
                grant_d = '0;
            end
        endcase

        grant_valid_d = |grant_d;
        grant_id_d    = IDX_W'(onehot_to_idx(ARB_MAX_N'(grant_d)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ARB_IDLE;
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            grant_id_q    <= '0;
            timeout_q     <= 1'b0;
            ptr_q         <= PTR_RST;
            hold_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            grant_valid_q <= grant_valid_d;
            grant_id_q    <= grant_id_d;
            timeout_q     <= timeout_d;
            ptr_q         <= ptr_d;
            hold_cnt_q    <= hold_cnt_d;
        end
    end

    assign grant       = grant_q;
    assign grant_valid = grant_valid_q;
    assign grant_id    = grant_id_q;
    assign timeout     = timeout_q;

endmodule
